// File: rtl/gen_sample_packer.sv
// gen_sample_packer
//   Sits behind funct_generator. It decimates the generator's sample stream
//   at a runtime ratio and packs two signed samples into each FIFO word. When
//   the FIFO is full, one completed word is held. Later kept samples are
//   dropped and counted.
//
//   Optional feature macro: GEN_PACK_FLUSH_EN. When it is defined, the block
//   adds a flush_i input. flush_i releases a half-filled word with a zero
//   upper half.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   en_i            block enable (0 discards any partial word and stops acceptance)
//   dec_i           decimation ratio N (keep 1 of every N; 0 acts as 1)
//   sample_valid_i  sample strobe from the generator (wr_en_o)
//   sample_i        signed sample from the generator (data_o)
//   fifo_full_i     FIFO full flag
//   flush_i         (GEN_PACK_FLUSH_EN only) release a half word
//   fifo_wr_o       FIFO write strobe
//   fifo_data_o     packed word: low half = older sample, high half = newer
//   drop_cnt_o      saturating count of dropped kept samples
//   overflow_o      sticky flag, set on the first drop
//   busy_o          high whenever a partial or pending word exists
//
// DATA_WIDTH defaults to 16, which is the value of fifo_defines_pkg::DATA_WIDTH
// used by the generator.
module gen_sample_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic [3:0]              dec_i,
  input  logic                    sample_valid_i,
  input  logic [DATA_WIDTH-1:0]   sample_i,
  input  logic                    fifo_full_i,
`ifdef GEN_PACK_FLUSH_EN
  input  logic                    flush_i,
`endif
  output logic                    fifo_wr_o,
  output logic [2*DATA_WIDTH-1:0] fifo_data_o,
  output logic [CNT_W-1:0]        drop_cnt_o,
  output logic                    overflow_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {EMPTY, HALF, PEND} state_t;

  state_t                state, state_nx;
  logic [3:0]            dec_cnt;
  logic [DATA_WIDTH-1:0] lo_q, hi_q;
  logic                  accept, kept;
  logic                  load_lo, load_hi, clr_hi, drop;
  logic                  flush;

`ifdef GEN_PACK_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    accept    = sample_valid_i && en_i;
    kept      = accept && (dec_cnt == '0);
    // Gated by rst so that a word pending at reset is never written.
    fifo_wr_o = (state == PEND) && !fifo_full_i && !rst;
    state_nx  = state;
    load_lo   = 1'b0;
    load_hi   = 1'b0;
    clr_hi    = 1'b0;
    drop      = 1'b0;
    case (state)
      EMPTY: begin
        if (kept) begin
          load_lo  = 1'b1;
          state_nx = HALF;
        end
      end
      HALF: begin
        if (!en_i) begin
          state_nx = EMPTY;
        end else if (kept) begin
          load_hi  = 1'b1;
          state_nx = PEND;
        end else if (flush) begin
          clr_hi   = 1'b1;
          state_nx = PEND;
        end
      end
      PEND: begin
        if (!fifo_full_i) begin
          // Write and accept a new lower half in the same cycle.
          if (kept) begin
            load_lo  = 1'b1;
            state_nx = HALF;
          end else begin
            state_nx = EMPTY;
          end
        end else if (kept) begin
          drop = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt    <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (!en_i) begin
        dec_cnt <= '0;
      end else if (accept) begin
        if (dec_cnt == '0) dec_cnt <= (dec_i == '0) ? 4'd0 : dec_i - 4'd1;
        else               dec_cnt <= dec_cnt - 4'd1;
      end
      if (load_lo) lo_q <= sample_i;
      if (load_hi) hi_q <= sample_i;
      else if (clr_hi) hi_q <= '0;
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
      end
    end
  end

  assign fifo_data_o = {hi_q, lo_q};
  assign busy_o      = (state != EMPTY);

endmodule

// File: doc/gen_sample_packer.md
Name: gen_sample_packer

Overview:
- Downstream stage of funct_generator. Consumes its sample stream (wr_en_o/data_o) and writes 2-sample packed words into the FIFO write port.
- Decimates the stream by a runtime ratio and packs two signed samples per FIFO word.
- Handles FIFO-full backpressure by holding one pending word, dropping later samples and counting the drops.

Parameters:
- DATA_WIDTH, default fifo_defines_pkg::DATA_WIDTH, width of one generator sample.
- CNT_W, default 8, width of the drop counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en_i  in  1  block enable.
- dec_i  in  4  decimation ratio; keep 1 of every N samples; 0 treated as 1.
- sample_valid_i  in  1  sample strobe (from generator wr_en_o).
- sample_i  in  DATA_WIDTH  signed sample (from generator data_o).
- fifo_full_i  in  1  FIFO full flag.
- fifo_wr_o  out  1  FIFO write strobe.
- fifo_data_o  out  2*DATA_WIDTH  packed word: [DATA_WIDTH-1:0] = older sample, upper half = newer sample.
- drop_cnt_o  out  CNT_W  count of dropped kept-samples; saturates at all-ones.
- overflow_o  out  1  sticky; set on first drop.
- busy_o  out  1  high when state != EMPTY.

Behaviour:
- Reset (synchronous, rst=1 at rising edge):
  - state=EMPTY, dec_cnt=0, fifo_data_o=0, fifo_wr_o=0, drop_cnt_o=0, overflow_o=0, busy_o=0.
  - Reset mid-PEND discards the pending word; no write is issued.
- Decimator:
  - A sample is accepted when sample_valid_i && en_i.
  - An accepted sample is "kept" iff dec_cnt==0.
  - On an accepted sample: dec_cnt <= (dec_cnt==0) ? max(dec_i,1)-1 : dec_cnt-1.
  - dec_i is sampled only at reload. A change takes effect after the current period.
- FSM states: EMPTY, HALF, PEND.
  - EMPTY + kept sample -> lower half <= sample, go to HALF.
  - HALF + kept sample -> upper half <= sample, go to PEND.
  - PEND: fifo_wr_o = !fifo_full_i (combinational from registered state). On a cycle with fifo_wr_o=1 the word is written.
    - With no kept sample that cycle -> go to EMPTY.
    - With a kept sample that cycle -> lower half <= sample, go to HALF (write and accept in the same cycle, no bubble).
  - PEND with fifo_full_i=1 + kept sample -> sample dropped; drop_cnt_o += 1 (saturating); overflow_o <= 1; stay in PEND.
  - fifo_data_o is stable for the whole time the block is in PEND.
- Latency: the second kept sample is registered at edge N. fifo_wr_o is high in the cycle following edge N if the FIFO is not full.
- Throughput: at most one FIFO write per two kept samples. A sustained rate of one kept sample per clock never drops while the FIFO is not full.
- Enable:
  - en_i=0 blocks sample acceptance and forces dec_cnt<=0.
  - en_i=0 in HALF discards the partial word (-> EMPTY).
  - A word already in PEND still drains while en_i=0.
- Arithmetic and flags:
  - Samples are stored unmodified (no sign extension; bit-exact halves).
  - drop_cnt_o and overflow_o clear only on rst.
- fifo_wr_o is never asserted while fifo_full_i=1.

Optional Feature:
- Macro: GEN_PACK_FLUSH_EN.
- Defined:
  - Adds input port flush_i (1 bit).
  - flush_i=1 in HALF (with no kept sample that cycle) -> upper half <= 0, go to PEND.
  - flush_i with a kept sample in HALF: the sample wins, giving a normal pairing.
  - flush_i in EMPTY or PEND has no effect.
- Undefined:
  - No flush_i port.
  - A partial word is released only by en_i=0 (discard) or by a second sample.

Test Plan:
- Basic pairing: rst, en_i=1, dec_i=1, fifo_full_i=0; samples 0x0011 then 0x0022 on consecutive cycles (DATA_WIDTH=16) -> fifo_wr_o pulses once, the cycle after the second sample, with fifo_data_o=0x00220011; busy_o returns low.
- Decimation: dec_i=3, samples 1..12 one per cycle -> kept 1,4,7,10 -> writes 0x00040001 and 0x000A0007 only.
- Backpressure: fifo_full_i=1 before the pair completes; three more kept samples -> fifo_wr_o stays 0, fifo_data_o held, drop_cnt_o=3, overflow_o=1. Release full -> exactly one write of the held word.
- Simultaneous event: PEND, fifo_full_i falls in the same cycle a kept sample 0x0055 arrives -> write issued, state=HALF, lower half=0x0055, no drop.
- Enable/reset mid-operation:
  - In HALF, drop en_i -> state EMPTY, no write.
  - In PEND with full=1, assert rst -> all outputs 0 next cycle, no write ever issued.
- Drop saturation (CNT_W=8): 300 drops -> drop_cnt_o=255.
- With GEN_PACK_FLUSH_EN: in HALF holding 0xFFFE, pulse flush_i -> write of 0x0000FFFE.
